// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - RV32I memory-op encodings and MEM-stage controller states
package rv32i_types;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010
    } store_funct3_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mem_ctrl_state_t;

endpackage

// File: rtl/mem_align.sv
// rtl/mem_align.sv - store lane replication/byte enables and load extract/extend
module mem_align
    import rv32i_types::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] store_src,
    input  logic [31:0] rdata,
    output logic        misaligned_addr,
    output logic [31:0] wdata,
    output logic [3:0]  mbe,
    output logic [31:0] load_ext
);

    logic [31:0] shifted;

    // Halves need an even address, words a word-aligned one; bytes are always aligned
    always_comb begin
        misaligned_addr = 1'b0;
        if (funct3[1])
            misaligned_addr = |offset;
        else if (funct3[0])
            misaligned_addr = offset[0];
    end

    // Replicate the store operand across lanes; byte enables pick the addressed lanes
    always_comb begin
        wdata = store_src;
        mbe   = 4'b1111;
        case (funct3[1:0])
            2'b00: begin
                wdata = {4{store_src[7:0]}};
                mbe   = 4'b0001 << offset;
            end
            2'b01: begin
                wdata = {2{store_src[15:0]}};
                mbe   = 4'b0011 << offset;
            end
            default: begin
                wdata = store_src;
                mbe   = 4'b1111;
            end
        endcase
    end

    // Bring the addressed byte/half down to bit 0, then sign- or zero-extend
    always_comb begin
        shifted  = rdata >> {offset, 3'b000};
        load_ext = rdata;
        case (load_funct3_t'(funct3))
            LB:      load_ext = {{24{shifted[7]}}, shifted[7:0]};
            LH:      load_ext = {{16{shifted[15]}}, shifted[15:0]};
            LBU:     load_ext = {24'd0, shifted[7:0]};
            LHU:     load_ext = {16'd0, shifted[15:0]};
            default: load_ext = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - MEM-stage data-memory request sequencer with stall, freeze hold and timeout
module mem_stage_ctrl
    import rv32i_types::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] alu_out,
    input  logic [31:0] rs2_out,
    input  logic        freeze,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [31:0] dmem_address,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_mbe,
    input  logic        dmem_resp,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        misaligned,
    output logic        bus_error
);

    // Counter holds the number of WAIT cycles already spent; the issue cycle is the first wait
    localparam int unsigned CW          = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam bit          HAS_TIMEOUT = (TIMEOUT_CYCLES != 0);
    localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT_CYCLES - 1);

    mem_ctrl_state_t state;
    logic [CW-1:0]   wait_cnt;
    logic [31:0]     hold_data;

    logic        mis_addr;
    logic        mem_op;
    logic        access;
    logic        at_limit;
    logic        req;
    logic [31:0] wdata_al;
    logic [3:0]  mbe_al;
    logic [31:0] load_ext;
    logic [31:0] live_load;

    mem_align u_align (
        .funct3          (funct3),
        .offset          (alu_out[1:0]),
        .store_src       (rs2_out),
        .rdata           (dmem_rdata),
        .misaligned_addr (mis_addr),
        .wdata           (wdata_al),
        .mbe             (mbe_al),
        .load_ext        (load_ext)
    );

    assign mem_op    = valid_in & (mem_read | mem_write);
    assign access    = mem_op & ~mis_addr;
    assign at_limit  = HAS_TIMEOUT && (state == WAIT) && (wait_cnt == LAST_WAIT);

    // Request is live when issuing from IDLE or still waiting; reset kills it at once
    assign req = ~rst & access & ((state == IDLE) | ((state == WAIT) & ~at_limit));

    // A store takes priority when both read and write are flagged
    assign dmem_read    = req & ~mem_write;
    assign dmem_write   = req & mem_write;
    assign dmem_address = req ? {alu_out[31:2], 2'b00} : 32'd0;
    assign dmem_wdata   = dmem_write ? wdata_al : 32'd0;
    assign dmem_mbe     = dmem_write ? mbe_al : 4'd0;
    assign stall        = req & ~dmem_resp;
    assign misaligned   = ~rst & mem_op & mis_addr;
    // A response landing in the limit cycle still completes the access
    assign bus_error    = ~rst & at_limit & ~dmem_resp;

    assign live_load = (access & ~mem_write & dmem_resp & (state != DONE)) ? load_ext : 32'd0;
    assign load_data = rst ? 32'd0 : ((state == DONE) ? hold_data : live_load);

    // Access sequencing: issue, wait for response or timeout, park in DONE while frozen
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            hold_data <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (access) begin
                        if (dmem_resp) begin
                            if (freeze) begin
                                state     <= DONE;
                                hold_data <= live_load;
                            end
                        end else begin
                            state    <= WAIT;
                            wait_cnt <= '0;
                        end
                    end
                end
                WAIT: begin
                    if (!access) begin
                        state    <= IDLE;
                        wait_cnt <= '0;
                    end else if (dmem_resp || at_limit) begin
                        state     <= freeze ? DONE : IDLE;
                        hold_data <= live_load;
                        wait_cnt  <= '0;
                    end else if (HAS_TIMEOUT) begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (!freeze)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb/tb_mem_stage_ctrl.sv - randomized self-checking bench for mem_stage_ctrl
module tb_mem_stage_ctrl;
    import rv32i_types::*;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in, mem_read, mem_write, freeze, dmem_resp;
    logic [2:0]  funct3;
    logic [31:0] alu_out, rs2_out, dmem_rdata;
    logic        dmem_read, dmem_write, stall, misaligned, bus_error;
    logic [31:0] dmem_address, dmem_wdata, load_data;
    logic [3:0]  dmem_mbe;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mbe;
        logic        stall;
        logic [31:0] ld;
        logic        mis;
        logic        berr;
    } obs_t;

    typedef struct {
        logic        v;
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] rs2;
        logic [31:0] rdata;
        int          lat;
    } txn_t;

    mem_stage_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_in     (valid_in),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .funct3       (funct3),
        .alu_out      (alu_out),
        .rs2_out      (rs2_out),
        .freeze       (freeze),
        .dmem_read    (dmem_read),
        .dmem_write   (dmem_write),
        .dmem_address (dmem_address),
        .dmem_wdata   (dmem_wdata),
        .dmem_mbe     (dmem_mbe),
        .dmem_resp    (dmem_resp),
        .dmem_rdata   (dmem_rdata),
        .stall        (stall),
        .load_data    (load_data),
        .misaligned   (misaligned),
        .bus_error    (bus_error)
    );

    always #5 clk = ~clk;

    function automatic obs_t sample();
        return {dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_mbe,
                stall, load_data, misaligned, bus_error};
    endfunction

    // Expected outputs in cycle c of an access whose response arrives in cycle lat
    function automatic obs_t model(input txn_t t, input int c);
        obs_t        e;
        int          size;
        int          off;
        logic [31:0] b;
        e    = '0;
        size = (t.f3[1:0] == 2'b00) ? 1 : ((t.f3[1:0] == 2'b01) ? 2 : 4);
        off  = int'(t.addr[1:0]);
        if (!(t.v && (t.rd || t.wr)))
            return e;
        if ((off % size) != 0) begin
            e.mis = 1'b1;
            return e;
        end
        if (c < TO) begin
            e.rd   = !t.wr;
            e.wr   = t.wr;
            e.addr = t.addr & 32'hFFFF_FFFC;
            if (t.wr) begin
                e.wdata = (size == 1) ? t.rs2[7:0] * 32'h0101_0101 :
                          (size == 2) ? t.rs2[15:0] * 32'h0001_0001 : t.rs2;
                e.mbe   = 4'(((1 << size) - 1) << off);
            end
        end
        e.stall = (c < t.lat);
        if (c == t.lat && !t.wr) begin
            b = t.rdata >> (8 * off);
            if (size == 1) begin
                b = b & 32'hFF;
                if (!t.f3[2] && b >= 32'h80) b = b + 32'hFFFF_FF00;
            end else if (size == 2) begin
                b = b & 32'hFFFF;
                if (!t.f3[2] && b >= 32'h8000) b = b + 32'hFFFF_0000;
            end
            e.ld = b;
        end
        return e;
    endfunction

    task automatic drive(input txn_t t);
        valid_in  = t.v;
        mem_read  = t.rd;
        mem_write = t.wr;
        funct3    = t.f3;
        alu_out   = t.addr;
        rs2_out   = t.rs2;
    endtask

    task automatic test_reset();
        obs_t got;
        txn_t t;
        t = '{v: 1'b1, rd: 1'b1, wr: 1'b0, f3: 3'b010, addr: 32'h10, rs2: 32'h0,
              rdata: 32'h1234_5678, lat: 0};
        rst = 1'b1;
        drive(t);
        dmem_resp  = 1'b1;
        dmem_rdata = t.rdata;
        @(negedge clk);
        got = sample();
        n_checks++;
        if (got !== obs_t'('0))
            $display("FAIL reset_outputs: got %h expected %h", got, obs_t'('0));
        else n_pass++;
        n_checks++;
        if (dut.state !== IDLE)
            $display("FAIL reset_state: got %0d expected %0d", dut.state, IDLE);
        else n_pass++;
        rst       = 1'b0;
        valid_in  = 1'b0;
        dmem_resp = 1'b0;
    endtask

    task automatic test_access();
        txn_t q[$];
        txn_t t;
        obs_t got, exp;
        int   ncyc;
        q.push_back('{1'b1, 1'b0, 1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 32'h0, 0});
        q.push_back('{1'b1, 1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 3});
        q.push_back('{1'b1, 1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 32'h8001_1234, 1});
        q.push_back('{1'b1, 1'b0, 1'b1, 3'b001, 32'h101, 32'h1111_2222, 32'h0, 0});
        q.push_back('{1'b1, 1'b1, 1'b1, 3'b000, 32'h0F1, 32'h0000_00A5, 32'h0, 2});
        q.push_back('{1'b1, 1'b1, 1'b0, 3'b001, 32'h106, 32'h0, 32'hFEDC_7654, TO});
        for (int i = 0; i < 60; i++) begin
            t.v     = ($urandom_range(0, 7) != 0);
            t.rd    = $urandom_range(0, 1);
            t.wr    = $urandom_range(0, 1);
            if (t.wr) t.f3 = 3'($urandom_range(0, 2));
            else begin
                t.f3 = 3'($urandom_range(0, 4));
                if (t.f3 == 3'd3) t.f3 = 3'b101;
            end
            t.addr  = $urandom;
            if ($urandom_range(0, 2) != 0) t.addr[1:0] = 2'b00;
            t.rs2   = $urandom;
            t.rdata = $urandom;
            t.lat   = $urandom_range(0, TO);
            q.push_back(t);
        end
        foreach (q[i]) begin
            t    = q[i];
            exp  = model(t, 0);
            ncyc = (exp.mis || !(t.v && (t.rd || t.wr))) ? 1 : t.lat + 1;
            for (int c = 0; c < ncyc; c++) begin
                @(posedge clk);
                #1;
                drive(t);
                dmem_resp  = (c == t.lat);
                dmem_rdata = (c == t.lat) ? t.rdata : $urandom;
                @(negedge clk);
                got = sample();
                exp = model(t, c);
                n_checks++;
                if (got !== exp)
                    $display("FAIL access[%0d] cyc %0d: got %h expected %h", i, c, got, exp);
                else n_pass++;
            end
        end
        @(posedge clk);
        #1;
        valid_in  = 1'b0;
        dmem_resp = 1'b0;
    endtask

    task automatic test_freeze();
        txn_t t0, t3;
        obs_t got, exp, held;
        t0 = '{1'b1, 1'b1, 1'b0, 3'b010, 32'h200, 32'h0, $urandom, 0};
        t3 = '{1'b1, 1'b1, 1'b0, 3'b010, 32'h204, 32'h0, $urandom, 0};
        held    = '0;
        held.ld = t0.rdata;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            drive((c == 3) ? t3 : t0);
            freeze     = (c < 2);
            dmem_resp  = (c == 0) || (c == 3);
            dmem_rdata = (c == 3) ? t3.rdata : ((c == 0) ? t0.rdata : $urandom);
            @(negedge clk);
            got = sample();
            exp = (c == 0) ? model(t0, 0) : ((c == 3) ? model(t3, 0) : held);
            n_checks++;
            if (got !== exp)
                $display("FAIL freeze cyc %0d: got %h expected %h", c, got, exp);
            else n_pass++;
        end
        freeze = 1'b0;
    endtask

    task automatic test_timeout();
        txn_t t;
        obs_t got, exp;
        t = '{1'b1, 1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 32'h0, 1000};
        for (int c = 0; c < TO + 2; c++) begin
            @(posedge clk);
            #1;
            drive(t);
            valid_in   = (c <= TO);
            dmem_resp  = 1'b0;
            dmem_rdata = $urandom;
            @(negedge clk);
            got = sample();
            if (c < TO) exp = model(t, c);
            else begin
                exp      = '0;
                exp.berr = (c == TO);
            end
            n_checks++;
            if (got !== exp)
                $display("FAIL timeout cyc %0d: got %h expected %h", c, got, exp);
            else n_pass++;
        end
    endtask

    task automatic test_reset_in_wait();
        txn_t t;
        obs_t got, exp;
        t = '{1'b1, 1'b1, 1'b0, 3'b000, 32'h40, 32'h0, 32'h0000_7F00, 1000};
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            drive(t);
            dmem_resp = 1'b0;
            @(negedge clk);
            got = sample();
            exp = model(t, c);
            n_checks++;
            if (got !== exp)
                $display("FAIL rstwait pre cyc %0d: got %h expected %h", c, got, exp);
            else n_pass++;
        end
        rst = 1'b1;
        #1;
        got = sample();
        n_checks++;
        if (got !== obs_t'('0))
            $display("FAIL rstwait drop: got %h expected %h", got, obs_t'('0));
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (dut.state !== IDLE)
            $display("FAIL rstwait state: got %0d expected %0d", dut.state, IDLE);
        else n_pass++;
        t.lat = 0;
        @(posedge clk);
        #1;
        drive(t);
        dmem_resp  = 1'b1;
        dmem_rdata = t.rdata;
        @(negedge clk);
        got = sample();
        exp = model(t, 0);
        n_checks++;
        if (got !== exp)
            $display("FAIL rstwait reissue: got %h expected %h", got, exp);
        else n_pass++;
        @(posedge clk);
        #1;
        valid_in  = 1'b0;
        dmem_resp = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        valid_in   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        funct3     = 3'b000;
        alu_out    = 32'd0;
        rs2_out    = 32'd0;
        freeze     = 1'b0;
        dmem_resp  = 1'b0;
        dmem_rdata = 32'd0;
        test_reset();
        test_access();
        test_freeze();
        test_timeout();
        test_reset_in_wait();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
